mest_pro_mem_ctrl: RTL and testbench

Memory access controller between the MESTPro core and the unified instruction/data memory. Memory accesses are mutually exclusive: fetch is selected by the chip-select, data access by write-enable/mm-select. This block serialises fetch, load and store requests from the core onto that single port, captures the registered memory outputs, and returns them with valid pulses. It also pre-checks addresses against the memory size and reports faults, including ROM-write errors flagged by the memory.

---
 rtl/mest_pro_mem_ctrl_pkg.sv | 23 ++
 rtl/mest_pro_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mest_pro_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mest_pro_mem_ctrl_pkg.sv
// Shared sizes, FSM state encodings and request-type codes for the
// MESTPro memory access controller.
package mest_pro_mem_ctrl_pkg;

    localparam int ADDR_BITS        = 8;
    localparam int DATA_BITS        = 16;
    localparam int INSTRUCTION_SIZE = 16;
    localparam int MEM_SIZE         = 256;
    localparam int ROM_SIZE         = 64;

    typedef enum logic [1:0] {
        MC_IDLE    = 2'd0,
        MC_ISSUE   = 2'd1,
        MC_CAPTURE = 2'd2
    } mc_state_t;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_LD    = 2'd1,
        REQ_ST    = 2'd2
    } req_type_t;

endpackage

// File: rtl/mest_pro_mem_ctrl.sv
// Memory access controller: serialises fetch/load/store requests from the
// MESTPro core onto the single unified memory port, range-checks addresses
// locally and returns captured memory data with one-cycle valid pulses.
module mest_pro_mem_ctrl #(
    parameter int ADDR_BITS        = mest_pro_mem_ctrl_pkg::ADDR_BITS,
    parameter int DATA_BITS        = mest_pro_mem_ctrl_pkg::DATA_BITS,
    parameter int INSTRUCTION_SIZE = mest_pro_mem_ctrl_pkg::INSTRUCTION_SIZE,
    parameter int MEM_SIZE         = mest_pro_mem_ctrl_pkg::MEM_SIZE
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        i_fetch_req,
    input  logic [ADDR_BITS-1:0]        i_pc,
    input  logic                        i_ld_req,
    input  logic                        i_st_req,
    input  logic [ADDR_BITS-1:0]        i_addr,
    input  logic [DATA_BITS-1:0]        i_wdata,
    output logic                        o_ready,
    output logic                        o_fetch_valid,
    output logic [INSTRUCTION_SIZE-1:0] o_inst,
    output logic                        o_ld_valid,
    output logic [INSTRUCTION_SIZE-1:0] o_ld_data,
    output logic                        o_st_done,
    output logic                        o_st_err,
    output logic                        o_fault,
    output logic [ADDR_BITS-1:0]        o_mem_prog_counter,
    output logic [ADDR_BITS-1:0]        o_mem_addr,
    output logic [DATA_BITS-1:0]        o_mem_in_dat,
    output logic                        o_mem_cs,
    output logic                        o_mem_we,
    output logic                        o_mem_mm_select,
    input  logic [INSTRUCTION_SIZE-1:0] i_mem_inst,
    input  logic [INSTRUCTION_SIZE-1:0] i_mem_dat,
    input  logic                        i_mem_error
);
    import mest_pro_mem_ctrl_pkg::*;

    mc_state_t            state;
    req_type_t            req_type;

    logic                 acc_any;
    req_type_t            acc_type;
    logic [ADDR_BITS-1:0] acc_addr;
    logic                 acc_fault;
    logic                 issue;

    // The address port may be wider than the memory, so out-of-range
    // addresses are caught here and never reach the memory.
    function automatic logic addr_out_of_range(input logic [ADDR_BITS-1:0] a);
        return (32'(a) >= 32'(MEM_SIZE));
    endfunction

    // Fixed-priority request selection: store over load over fetch.
    always_comb begin
        acc_any  = i_fetch_req | i_ld_req | i_st_req;
        acc_type = REQ_FETCH;
        acc_addr = i_pc;
        if (i_st_req) begin
            acc_type = REQ_ST;
            acc_addr = i_addr;
        end else if (i_ld_req) begin
            acc_type = REQ_LD;
            acc_addr = i_addr;
        end
    end

    assign acc_fault = addr_out_of_range(acc_addr);

    // Strobes are only live while the latched request is being issued;
    // the memory samples them on the edge that ends ISSUE.
    assign issue           = (state == MC_ISSUE);
    assign o_mem_cs        = issue && (req_type == REQ_FETCH);
    assign o_mem_we        = issue && (req_type == REQ_ST);
    assign o_mem_mm_select = issue && (req_type == REQ_LD);

    // Controller FSM with registered responses, request latches and sticky fault.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state              <= MC_IDLE;
            req_type           <= REQ_FETCH;
            o_ready            <= 1'b1;
            o_fetch_valid      <= 1'b0;
            o_ld_valid         <= 1'b0;
            o_st_done          <= 1'b0;
            o_st_err           <= 1'b0;
            o_fault            <= 1'b0;
            o_inst             <= '0;
            o_ld_data          <= '0;
            o_mem_prog_counter <= '0;
            o_mem_addr         <= '0;
            o_mem_in_dat       <= '0;
        end else begin
            o_fetch_valid <= 1'b0;
            o_ld_valid    <= 1'b0;
            o_st_done     <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (acc_any) begin
                        if (acc_fault) begin
                            // Rejected locally: answer next cycle, stay idle.
                            o_fault <= 1'b1;
                            case (acc_type)
                                REQ_FETCH: begin
                                    o_fetch_valid <= 1'b1;
                                    o_inst        <= '0;
                                end
                                REQ_LD: begin
                                    o_ld_valid <= 1'b1;
                                    o_ld_data  <= '0;
                                end
                                REQ_ST: begin
                                    o_st_done <= 1'b1;
                                    o_st_err  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end else begin
                            req_type <= acc_type;
                            state    <= MC_ISSUE;
                            o_ready  <= 1'b0;
                            case (acc_type)
                                REQ_FETCH: o_mem_prog_counter <= acc_addr;
                                REQ_LD:    o_mem_addr         <= acc_addr;
                                REQ_ST: begin
                                    o_mem_addr   <= acc_addr;
                                    o_mem_in_dat <= i_wdata;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                MC_ISSUE: begin
                    state <= MC_CAPTURE;
                end
                MC_CAPTURE: begin
                    // Memory outputs are registered, so they are valid now.
                    state   <= MC_IDLE;
                    o_ready <= 1'b1;
                    case (req_type)
                        REQ_FETCH: begin
                            o_inst        <= i_mem_inst;
                            o_fetch_valid <= 1'b1;
                        end
                        REQ_LD: begin
                            o_ld_data  <= i_mem_dat;
                            o_ld_valid <= 1'b1;
                        end
                        REQ_ST: begin
                            o_st_err  <= i_mem_error;
                            o_st_done <= 1'b1;
                            if (i_mem_error) begin
                                o_fault <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state   <= MC_IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mest_pro_mem_ctrl.sv
// Directed testbench for mest_pro_mem_ctrl with a small behavioural
// unified memory (ROM region rejects writes with a registered error).
module tb_mest_pro_mem_ctrl;
    import mest_pro_mem_ctrl_pkg::*;

    localparam int TB_ADDR_BITS = 9;
    localparam int TB_MEM_SIZE  = 256;

    logic                    CLK;
    logic                    RESET;
    logic                    i_fetch_req;
    logic [TB_ADDR_BITS-1:0] i_pc;
    logic                    i_ld_req;
    logic                    i_st_req;
    logic [TB_ADDR_BITS-1:0] i_addr;
    logic [15:0]             i_wdata;
    logic                    o_ready;
    logic                    o_fetch_valid;
    logic [15:0]             o_inst;
    logic                    o_ld_valid;
    logic [15:0]             o_ld_data;
    logic                    o_st_done;
    logic                    o_st_err;
    logic                    o_fault;
    logic [TB_ADDR_BITS-1:0] o_mem_prog_counter;
    logic [TB_ADDR_BITS-1:0] o_mem_addr;
    logic [15:0]             o_mem_in_dat;
    logic                    o_mem_cs;
    logic                    o_mem_we;
    logic                    o_mem_mm_select;
    logic [15:0]             mem_inst;
    logic [15:0]             mem_dat;
    logic                    mem_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:511];

    mest_pro_mem_ctrl #(
        .ADDR_BITS       (TB_ADDR_BITS),
        .DATA_BITS       (16),
        .INSTRUCTION_SIZE(16),
        .MEM_SIZE        (TB_MEM_SIZE)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .i_fetch_req       (i_fetch_req),
        .i_pc              (i_pc),
        .i_ld_req          (i_ld_req),
        .i_st_req          (i_st_req),
        .i_addr            (i_addr),
        .i_wdata           (i_wdata),
        .o_ready           (o_ready),
        .o_fetch_valid     (o_fetch_valid),
        .o_inst            (o_inst),
        .o_ld_valid        (o_ld_valid),
        .o_ld_data         (o_ld_data),
        .o_st_done         (o_st_done),
        .o_st_err          (o_st_err),
        .o_fault           (o_fault),
        .o_mem_prog_counter(o_mem_prog_counter),
        .o_mem_addr        (o_mem_addr),
        .o_mem_in_dat      (o_mem_in_dat),
        .o_mem_cs          (o_mem_cs),
        .o_mem_we          (o_mem_we),
        .o_mem_mm_select   (o_mem_mm_select),
        .i_mem_inst        (mem_inst),
        .i_mem_dat         (mem_dat),
        .i_mem_error       (mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Unified memory with registered outputs; ROM region raises an error on write.
    always @(posedge CLK) begin
        if (o_mem_cs) mem_inst <= mem[o_mem_prog_counter];
        if (o_mem_mm_select && !o_mem_we) mem_dat <= mem[o_mem_addr];
        mem_err <= o_mem_we && (int'(o_mem_addr) < ROM_SIZE);
        if (o_mem_we && int'(o_mem_addr) >= ROM_SIZE) mem[o_mem_addr] <= o_mem_in_dat;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        mem[0]   = 16'hBEEF;
        mem[5]   = 16'hA5A5;
        mem[6]   = 16'h6666;
        mem_inst = '0;
        mem_dat  = '0;
        mem_err  = 1'b0;
        RESET       = 1'b1;
        i_fetch_req = 1'b0;
        i_ld_req    = 1'b0;
        i_st_req    = 1'b0;
        i_pc        = '0;
        i_addr      = '0;
        i_wdata     = '0;
        step();
        step();

        // Reset state
        check_val("rst_ready", o_ready, 1);
        check_val("rst_pulses", {o_fetch_valid, o_ld_valid, o_st_done}, 0);
        check_val("rst_inst", o_inst, 0);
        check_val("rst_ld_data", o_ld_data, 0);
        check_val("rst_st_err_fault", {o_st_err, o_fault}, 0);
        check_val("rst_strobes", {o_mem_cs, o_mem_we, o_mem_mm_select}, 0);
        check_val("rst_mem_outs", {o_mem_prog_counter, o_mem_addr, o_mem_in_dat}, 0);
        RESET = 1'b0;
        step();

        // Fetch pc=5
        i_fetch_req = 1'b1;
        i_pc        = 9'd5;
        check_val("f_c0_cs", o_mem_cs, 0);
        step();
        i_fetch_req = 1'b0;
        check_val("f_c1_cs", o_mem_cs, 1);
        check_val("f_c1_pc", o_mem_prog_counter, 5);
        check_val("f_c1_ready", o_ready, 0);
        step();
        check_val("f_c2_cs", o_mem_cs, 0);
        check_val("f_c2_valid", o_fetch_valid, 0);
        step();
        check_val("f_c3_valid", o_fetch_valid, 1);
        check_val("f_c3_inst", o_inst, 16'hA5A5);
        check_val("f_c3_ready", o_ready, 1);
        step();
        check_val("f_c4_valid", o_fetch_valid, 0);
        check_val("f_c4_inst_hold", o_inst, 16'hA5A5);

        // Store 1234 to ROM_SIZE, then load it back
        i_st_req = 1'b1;
        i_addr   = 9'(ROM_SIZE);
        i_wdata  = 16'h1234;
        step();
        i_st_req = 1'b0;
        check_val("s_c1_we", o_mem_we, 1);
        check_val("s_c1_cs", o_mem_cs, 0);
        check_val("s_c1_addr", o_mem_addr, ROM_SIZE);
        check_val("s_c1_dat", o_mem_in_dat, 16'h1234);
        step();
        check_val("s_c2_we", o_mem_we, 0);
        step();
        check_val("s_c3_done", o_st_done, 1);
        check_val("s_c3_err", o_st_err, 0);
        check_val("s_c3_fault", o_fault, 0);
        i_ld_req = 1'b1;
        step();
        i_ld_req = 1'b0;
        check_val("l_c1_mm", {o_mem_cs, o_mem_we, o_mem_mm_select}, 3'b001);
        step();
        step();
        check_val("l_c3_valid", o_ld_valid, 1);
        check_val("l_c3_data", o_ld_data, 16'h1234);

        // Store to ROM address 0 -> error, sticky fault
        i_st_req = 1'b1;
        i_addr   = 9'd0;
        i_wdata  = 16'h7777;
        step();
        i_st_req = 1'b0;
        step();
        step();
        check_val("rom_done", o_st_done, 1);
        check_val("rom_err", o_st_err, 1);
        check_val("rom_fault", o_fault, 1);
        i_ld_req = 1'b1;
        step();
        i_ld_req = 1'b0;
        step();
        step();
        check_val("rom_ld_valid", o_ld_valid, 1);
        check_val("rom_ld_data", o_ld_data, 16'hBEEF);
        check_val("rom_fault_sticky", o_fault, 1);

        // All three requests together: store, then load, then fetch
        do_reset();
        check_val("rst2_fault", o_fault, 0);
        i_st_req    = 1'b1;
        i_ld_req    = 1'b1;
        i_fetch_req = 1'b1;
        i_addr      = 9'd70;
        i_wdata     = 16'h5555;
        i_pc        = 9'd6;
        step();
        i_st_req = 1'b0;
        check_val("pri_c1_we", o_mem_we, 1);
        check_val("pri_c1_addr", o_mem_addr, 70);
        i_addr = 9'd64;
        step();
        step();
        check_val("pri_c3_pulses", {o_st_done, o_ld_valid, o_fetch_valid}, 3'b100);
        check_val("pri_c3_ready", o_ready, 1);
        step();
        i_ld_req = 1'b0;
        check_val("pri_c4_mm", o_mem_mm_select, 1);
        check_val("pri_c4_addr", o_mem_addr, 64);
        step();
        step();
        check_val("pri_c6_pulses", {o_st_done, o_ld_valid, o_fetch_valid}, 3'b010);
        check_val("pri_c6_ld_data", o_ld_data, 16'h1234);
        step();
        i_fetch_req = 1'b0;
        check_val("pri_c7_cs", o_mem_cs, 1);
        check_val("pri_c7_pc", o_mem_prog_counter, 6);
        step();
        step();
        check_val("pri_c9_pulses", {o_st_done, o_ld_valid, o_fetch_valid}, 3'b001);
        check_val("pri_c9_inst", o_inst, 16'h6666);

        // Out-of-range load, fetch and store
        i_ld_req = 1'b1;
        i_addr   = 9'(TB_MEM_SIZE);
        step();
        i_ld_req = 1'b0;
        check_val("rng_ld_valid", o_ld_valid, 1);
        check_val("rng_ld_data", o_ld_data, 0);
        check_val("rng_ld_fault", o_fault, 1);
        check_val("rng_ld_ready", o_ready, 1);
        check_val("rng_ld_strobes", {o_mem_cs, o_mem_we, o_mem_mm_select}, 0);
        i_fetch_req = 1'b1;
        i_pc        = 9'd300;
        step();
        i_fetch_req = 1'b0;
        check_val("rng_f_valid", o_fetch_valid, 1);
        check_val("rng_f_inst", o_inst, 0);
        check_val("rng_f_cs", o_mem_cs, 0);
        i_st_req = 1'b1;
        i_addr   = 9'd511;
        step();
        i_st_req = 1'b0;
        check_val("rng_st_done_err", {o_st_done, o_st_err}, 2'b11);
        check_val("rng_st_we", o_mem_we, 0);
        check_val("rng_st_addr_hold", o_mem_addr, 64);

        // Reset during CAPTURE of a load aborts it
        do_reset();
        i_ld_req = 1'b1;
        i_addr   = 9'd64;
        step();
        i_ld_req = 1'b0;
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check_val("abort_valid", o_ld_valid, 0);
        check_val("abort_ready", o_ready, 1);
        check_val("abort_ld_data", o_ld_data, 0);
        check_val("abort_strobes", {o_mem_cs, o_mem_we, o_mem_mm_select}, 0);
        check_val("abort_mem_addr", o_mem_addr, 0);
        step();
        check_val("abort_no_late_valid", o_ld_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
